// File: rtl/cmd_frame_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cmd_frame_rx_if
// Description : Bundle of signals between a UART byte source / host and the
//               command frame receiver.
//               master : drives rx_data, rx_rdy, clr_cmd_rdy; observes the rest
//               slave  : the receiver (cmd_frame_rx)
//               DATA_BYTES must match the receiver's DATA_BYTES.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmd_frame_rx_if #(
  parameter int DATA_BYTES = 2
) ();

  logic [7:0]              rx_data;     // byte from UART core
  logic                    rx_rdy;      // UART byte-available level
  logic                    clr_rx_rdy;  // consume strobe back to UART core
  logic                    clr_cmd_rdy; // host acknowledge
  logic                    cmd_rdy;     // frame presented on cmd/data
  logic [7:0]              cmd;         // opcode of last good frame
  logic [8*DATA_BYTES-1:0] data;        // payload of last good frame
  logic                    chk_err;     // one-cycle bad check byte pulse
  logic                    timeout;     // one-cycle partial-frame discard pulse
  logic                    overrun;     // sticky unacknowledged overwrite flag
  logic                    busy;        // receiver mid-frame

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy,
    input  clr_rx_rdy, cmd_rdy, cmd, data, chk_err, timeout, overrun, busy
  );

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy,
    output clr_rx_rdy, cmd_rdy, cmd, data, chk_err, timeout, overrun, busy
  );

endinterface
`default_nettype wire

// File: rtl/cmd_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cmd_frame_rx
// Description : Assembles command frames (opcode, DATA_BYTES payload bytes,
//               optional XOR check byte) from a UART byte stream and presents
//               them to a host with a ready/acknowledge handshake.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - cmd_frame_rx_if.slave:
//                        rx_data/rx_rdy in, clr_rx_rdy out (UART side)
//                        clr_cmd_rdy in, cmd_rdy/cmd/data out (host side)
//                        chk_err/timeout pulses, overrun sticky, busy status
// Parameters  : DATA_BYTES (1..4), MSB_FIRST, CHKSUM_EN, TIMEOUT_CYCLES (0=off)
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_rx #(
  parameter int DATA_BYTES     = 2,
  parameter int MSB_FIRST      = 1,
  parameter int CHKSUM_EN      = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  cmd_frame_rx_if.slave     bus
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CHK  = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;      // payload byte index within frame
  logic [7:0]       cmd_sh_q,  cmd_sh_d;   // shadow opcode
  logic [DW-1:0]    data_sh_q, data_sh_d;  // shadow payload
  logic [7:0]       xor_q,     xor_d;      // running XOR of opcode and payload
  logic [7:0]       cmd_q,     cmd_d;
  logic [DW-1:0]    data_q,    data_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             overrun_q, overrun_d;
  logic             chk_err_q, chk_err_d;
  logic             timeout_q, timeout_d;

  logic             frame_good;  // frame completes good this cycle
  logic             frame_bad;   // frame rejected on check byte this cycle
  logic             tmo_hit;     // inter-byte timeout expires this cycle

  // --------------------------------------------------------------------------
  // Inter-byte idle counter. A byte arriving in the expiry cycle wins, so the
  // expiry condition is qualified with !rx_rdy.
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign tmo_hit = (state_q != S_IDLE) && !bus.rx_rdy &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

      always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((state_q == S_IDLE) || bus.rx_rdy || tmo_hit) begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame FSM and shadow assembly
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cmd_sh_d   = cmd_sh_q;
    data_sh_d  = data_sh_q;
    xor_d      = xor_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_rdy) begin
          cmd_sh_d  = bus.rx_data;
          data_sh_d = '0;
          xor_d     = bus.rx_data;
          idx_d     = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (bus.rx_rdy) begin
          // Steer the byte into its lane; lane order depends on MSB_FIRST.
          for (int k = 0; k < DATA_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              data_sh_d[8*((MSB_FIRST != 0) ? (DATA_BYTES-1-k) : k) +: 8] = bus.rx_data;
            end
          end
          xor_d = xor_q ^ bus.rx_data;
          if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
            idx_d = '0;
            if (CHKSUM_EN != 0) begin
              state_d = S_CHK;
            end else begin
              state_d    = S_IDLE;
              frame_good = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          cmd_sh_d  = '0;
          data_sh_d = '0;
          xor_d     = '0;
        end
      end

      S_CHK: begin
        if (bus.rx_rdy) begin
          state_d = S_IDLE;
          if (bus.rx_data == xor_q) begin
            frame_good = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          cmd_sh_d  = '0;
          data_sh_d = '0;
          xor_d     = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Host-facing outputs. A good completion takes priority over an acknowledge
  // in the same cycle; the acknowledge still clears a pending overrun.
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q;
    overrun_d = overrun_q;
    chk_err_d = frame_bad;
    timeout_d = tmo_hit;

    if (frame_good) begin
      // In the payload-completion case the shadow _d values already hold the
      // final byte; in the check-byte case they equal the _q values.
      cmd_d     = cmd_sh_d;
      data_d    = data_sh_d;
      cmd_rdy_d = 1'b1;
      if (bus.clr_cmd_rdy) begin
        overrun_d = 1'b0;
      end else if (cmd_rdy_q) begin
        overrun_d = 1'b1;
      end
    end else if (bus.clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cmd_sh_q  <= '0;
      data_sh_q <= '0;
      xor_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      chk_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmd_sh_q  <= cmd_sh_d;
      data_sh_q <= data_sh_d;
      xor_q     <= xor_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
      chk_err_q <= chk_err_d;
      timeout_q <= timeout_d;
    end
  end

  // Each byte is consumed in the cycle it is seen, in every state.
  assign bus.clr_rx_rdy = bus.rx_rdy;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.cmd        = cmd_q;
  assign bus.data       = data_q;
  assign bus.chk_err    = chk_err_q;
  assign bus.timeout    = timeout_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cmd_frame_rx
// Description : Self-checking bench for cmd_frame_rx. Two instances:
//               A: DATA_BYTES=2, MSB_FIRST=1, CHKSUM_EN=0, TIMEOUT_CYCLES=16
//               B: DATA_BYTES=3, MSB_FIRST=0, CHKSUM_EN=1, TIMEOUT_CYCLES=0
//               Expected values come from a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_rx;

  localparam int A_DB = 2, A_MSB = 1, A_CHK = 0, A_TO = 16;
  localparam int B_DB = 3, B_MSB = 0, B_CHK = 1, B_TO = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_frame_rx_if #(.DATA_BYTES(A_DB)) ifa ();
  cmd_frame_rx_if #(.DATA_BYTES(B_DB)) ifb ();

  cmd_frame_rx #(.DATA_BYTES(A_DB), .MSB_FIRST(A_MSB), .CHKSUM_EN(A_CHK),
                 .TIMEOUT_CYCLES(A_TO)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  cmd_frame_rx #(.DATA_BYTES(B_DB), .MSB_FIRST(B_MSB), .CHKSUM_EN(B_CHK),
                 .TIMEOUT_CYCLES(B_TO)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_pass  = 0;
  int n_total = 0;

  // reference model state, index 0 = A, 1 = B
  int          cfg_db [2];
  bit          cfg_msb[2];
  bit          cfg_chk[2];
  logic [7:0]  pb     [2][8];   // bytes of the frame in progress
  int          pn     [2];      // number of bytes in progress
  logic [7:0]  m_cmd  [2];
  logic [31:0] m_data [2];
  bit          m_rdy  [2];
  bit          m_ovr  [2];
  int          idle_a;          // cycles since A's last consumed byte

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_total = n_total + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
  endtask

  task automatic drive(int s, logic [7:0] b, bit rdy, bit clr);
    if (s == 0) begin
      ifa.rx_data = b; ifa.rx_rdy = rdy; ifa.clr_cmd_rdy = clr;
    end else begin
      ifb.rx_data = b; ifb.rx_rdy = rdy; ifb.clr_cmd_rdy = clr;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      pn[s] = 0; m_cmd[s] = '0; m_data[s] = '0; m_rdy[s] = 0; m_ovr[s] = 0;
    end
    idle_a = 0;
  endtask

  // Frame-level model: collect bytes, judge the frame when complete.
  task automatic model_byte(int s, logic [7:0] b, bit clr, output bit ce);
    int flen; logic [7:0] x; logic [31:0] d; bit good;
    flen = 1 + cfg_db[s] + (cfg_chk[s] ? 1 : 0);
    pb[s][pn[s]] = b;
    pn[s]++;
    good = 0;
    ce   = 0;
    if (pn[s] == flen) begin
      pn[s] = 0;
      x = '0;
      for (int i = 0; i <= cfg_db[s]; i++) x ^= pb[s][i];
      good = !cfg_chk[s] || (pb[s][flen-1] == x);
      ce   = !good;
      if (good) begin
        d = '0;
        for (int k = 0; k < cfg_db[s]; k++)
          d = d | (32'(pb[s][1+k]) << (8 * (cfg_msb[s] ? (cfg_db[s]-1-k) : k)));
        m_cmd[s]  = pb[s][0];
        m_data[s] = d;
        if (clr) m_ovr[s] = 0;
        else if (m_rdy[s]) m_ovr[s] = 1;
        m_rdy[s] = 1;
      end
    end
    if (!good && clr) begin
      m_rdy[s] = 0; m_ovr[s] = 0;
    end
  endtask

  // A discards a partial frame after A_TO consecutive byte-less cycles.
  task automatic edge_a(bit a_byte, output bit to_exp);
    to_exp = 0;
    if (a_byte) idle_a = 0;
    else begin
      idle_a++;
      if (pn[0] > 0 && idle_a == A_TO) begin
        to_exp = 1;
        pn[0]  = 0;
      end
    end
  endtask

  task automatic check_outputs(int s, bit exp_ce, bit exp_to, string ctx);
    logic [7:0] c; logic [31:0] d; logic r, o, ce, to, b;
    string nm;
    nm = (s == 0) ? "a" : "b";
    if (s == 0) begin
      c = ifa.cmd; d = 32'(ifa.data); r = ifa.cmd_rdy; o = ifa.overrun;
      ce = ifa.chk_err; to = ifa.timeout; b = ifa.busy;
    end else begin
      c = ifb.cmd; d = 32'(ifb.data); r = ifb.cmd_rdy; o = ifb.overrun;
      ce = ifb.chk_err; to = ifb.timeout; b = ifb.busy;
    end
    chk($sformatf("%s.%s.cmd", ctx, nm),     32'(c),  32'(m_cmd[s]));
    chk($sformatf("%s.%s.data", ctx, nm),    d,       m_data[s]);
    chk($sformatf("%s.%s.cmd_rdy", ctx, nm), 32'(r),  32'(m_rdy[s]));
    chk($sformatf("%s.%s.overrun", ctx, nm), 32'(o),  32'(m_ovr[s]));
    chk($sformatf("%s.%s.chk_err", ctx, nm), 32'(ce), 32'(exp_ce));
    chk($sformatf("%s.%s.timeout", ctx, nm), 32'(to), 32'(exp_to));
    chk($sformatf("%s.%s.busy", ctx, nm),    32'(b),  32'(pn[s] > 0));
  endtask

  task automatic after_edge(int bsel, bit ce, string ctx);
    bit to_a;
    edge_a(bsel == 0, to_a);
    check_outputs(0, (bsel == 0) ? ce : 1'b0, to_a, ctx);
    check_outputs(1, (bsel == 1) ? ce : 1'b0, 1'b0, ctx);
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(int s, logic [7:0] b, bit clr);
    bit ce;
    drive(s, b, 1'b1, clr);
    #1;
    chk($sformatf("byte.%0d.clr_rx_rdy", s),
        32'((s == 0) ? ifa.clr_rx_rdy : ifb.clr_rx_rdy), 32'd1);
    @(posedge clk); #1;
    model_byte(s, b, clr, ce);
    after_edge(s, ce, "byte");
    drive(s, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      after_edge(-1, 1'b0, "idle");
      chk("idle.clr_rx_rdy", {30'd0, ifa.clr_rx_rdy, ifb.clr_rx_rdy}, 32'd0);
    end
  endtask

  task automatic ack(int s);
    drive(s, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    m_rdy[s] = 0; m_ovr[s] = 0;
    after_edge(-1, 1'b0, "ack");
    drive(s, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(0, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 1'b0, 1'b0);
    model_reset();
    #1;
    check_outputs(0, 1'b0, 1'b0, "rst_async");
    check_outputs(1, 1'b0, 1'b0, "rst_async");
    @(posedge clk); @(posedge clk); #1;
    check_outputs(0, 1'b0, 1'b0, "rst_hold");
    check_outputs(1, 1'b0, 1'b0, "rst_hold");
    rst = 1'b0;
  endtask

  task automatic send_frame(int s, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                            logic [7:0] b3, logic [7:0] b4, int nb, bit clr_last);
    logic [7:0] fb[5];
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
    for (int i = 0; i < nb; i++) send_byte(s, fb[i], (i == nb-1) && clr_last);
  endtask

  initial begin
    cfg_db[0] = A_DB; cfg_msb[0] = (A_MSB != 0); cfg_chk[0] = (A_CHK != 0);
    cfg_db[1] = B_DB; cfg_msb[1] = (B_MSB != 0); cfg_chk[1] = (B_CHK != 0);
    rst = 1'b1;
    drive(0, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    pulse_reset();
    idle(2);

    // basic frame, MSB first
    send_frame(0, 8'h05, 8'h12, 8'h34, 0, 0, 3, 0);
    chk("basic.cmd_lit",  32'(ifa.cmd),  32'h05);
    chk("basic.data_lit", 32'(ifa.data), 32'h1234);
    idle(1);
    ack(0);
    chk("basic.ack_rdy_lit", 32'(ifa.cmd_rdy), 32'd0);

    // LSB first, 3 payload bytes, good then bad check byte
    send_frame(1, 8'hA0, 8'h11, 8'h22, 8'h33, 8'hA0, 5, 0);
    chk("lsb.cmd_lit",  32'(ifb.cmd),  32'hA0);
    chk("lsb.data_lit", 32'(ifb.data), 32'h332211);
    ack(1);
    send_frame(1, 8'hA0, 8'h11, 8'h22, 8'h33, 8'h00, 5, 0);
    chk("badchk.pulse_lit", 32'(ifb.chk_err), 32'd1);
    chk("badchk.rdy_lit",   32'(ifb.cmd_rdy), 32'd0);
    idle(1);

    // timeout after 16 idle cycles, then a clean frame
    send_frame(0, 8'h07, 8'h99, 0, 0, 0, 2, 0);
    idle(A_TO);
    chk("tmo.pulse_lit", 32'(ifa.timeout), 32'd1);
    chk("tmo.busy_lit",  32'(ifa.busy),    32'd0);
    idle(2);
    send_frame(0, 8'h08, 8'h01, 8'h02, 0, 0, 3, 0);
    chk("tmo.data_lit", 32'(ifa.data), 32'h0102);
    ack(0);

    // byte arriving in the expiry cycle is accepted
    send_byte(0, 8'h07, 0);
    idle(A_TO - 1);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    chk("tmo_edge.data_lit", 32'(ifa.data), 32'h1122);
    ack(0);

    // overrun, acknowledge, completion beating a same-cycle acknowledge
    send_frame(0, 8'h11, 8'h22, 8'h33, 0, 0, 3, 0);
    send_frame(0, 8'h44, 8'h55, 8'h66, 0, 0, 3, 0);
    chk("ovr.set_lit",  32'(ifa.overrun), 32'd1);
    chk("ovr.data_lit", 32'(ifa.data),    32'h5566);
    ack(0);
    chk("ovr.clr_lit",  32'(ifa.overrun), 32'd0);
    send_frame(0, 8'h21, 8'h00, 8'h01, 0, 0, 3, 0);
    send_frame(0, 8'h22, 8'h00, 8'h02, 0, 0, 3, 1);
    chk("race.rdy_lit", 32'(ifa.cmd_rdy), 32'd1);
    chk("race.ovr_lit", 32'(ifa.overrun), 32'd0);
    ack(0);

    // reset mid-frame
    send_frame(0, 8'h55, 8'h66, 0, 0, 0, 2, 0);
    pulse_reset();
    send_frame(0, 8'h09, 8'hAB, 8'hCD, 0, 0, 3, 0);
    chk("rstmid.cmd_lit",  32'(ifa.cmd),  32'h09);
    chk("rstmid.data_lit", 32'(ifa.data), 32'hABCD);
    ack(0);

    // randomized frames with random gaps, checks, acks
    for (int f = 0; f < 60; f++) begin
      int s; int nb; int g;
      logic [7:0] fb[8]; logic [7:0] x; bit good_chk; bit clr_last;
      s  = $urandom_range(0, 1);
      nb = 1 + cfg_db[s];
      x  = '0;
      for (int i = 0; i < nb; i++) begin
        fb[i] = 8'($urandom);
        x ^= fb[i];
      end
      good_chk = 1;
      if (cfg_chk[s]) begin
        good_chk = ($urandom_range(0, 3) != 0);
        fb[nb]   = good_chk ? x : (x ^ 8'($urandom_range(1, 255)));
        nb++;
      end
      clr_last = good_chk && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < nb; i++) begin
        send_byte(s, fb[i], (i == nb-1) && clr_last);
        if (i != nb-1) begin
          g = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
          idle(g);
        end
      end
      if ($urandom_range(0, 2) == 0) ack(s);
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
